// File: rtl/mcdt_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcdt_arb_pkg : shared types and constants for the round-robin arbiter |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package mcdt_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Legacy idle-bus patterns; users resize them to the instance widths.
    localparam logic [31:0] c_IDLE_DATA = 32'hffff_ffff;
    localparam logic [3:0]  c_IDLE_ID   = 4'hf;
    localparam int          c_CNT_W     = 8;

    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcdt_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcdt_rr_pick : first requester at or after ptr, wrapping modulo NCH  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module mcdt_rr_pick
    import mcdt_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IDW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [IDW-1:0] w_cand;

    // Scan farthest-first so the nearest requester is the last one written.
    always_comb begin
        idx    = '0;
        any    = |req;
        w_cand = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_cand = IDW'(rr_wrap(int'(ptr), i, NCH));
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcdt_rr_arb_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcdt_rr_arb_n : N-channel round-robin burst arbiter, registered out  |
// |                 Optional sticky protocol check: MCDT_ARB_ERR_CHK_EN  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module mcdt_rr_arb_n
    import mcdt_arb_pkg::*;
#(
    parameter  int NCH       = 4,
    parameter  int DW        = 32,
    parameter  int MAX_BURST = 8,
    localparam int IDW       = $clog2(NCH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    slv_req_i,
    input  logic [NCH-1:0]    slv_val_i,
    input  logic [NCH*DW-1:0] slv_data_i,
    output logic [NCH-1:0]    a2s_ack_o,
    input  logic              data_rdy_i,
    output logic              data_val_o,
    output logic [IDW-1:0]    arb_id_o,
    output logic [DW-1:0]     arb_data_o,
    output logic              err_o
);

    localparam logic [DW+31:0]     c_IDLE_DATA_EXT = {{DW{1'b1}}, c_IDLE_DATA};
    localparam logic [DW-1:0]      c_IDLE_DATA_W   = c_IDLE_DATA_EXT[DW-1:0];
    localparam logic [IDW+3:0]     c_IDLE_ID_EXT   = {{IDW{1'b1}}, c_IDLE_ID};
    localparam logic [IDW-1:0]     c_IDLE_ID_W     = c_IDLE_ID_EXT[IDW-1:0];
    localparam logic [c_CNT_W-1:0] c_MAX_CNT       = c_CNT_W'(MAX_BURST);
    localparam logic [IDW-1:0]     c_LAST_CH       = IDW'(NCH - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [IDW-1:0]     r_gnt, w_gnt_nxt;
    logic [IDW-1:0]     r_ptr, w_ptr_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               r_val, w_val_nxt;
    logic [IDW-1:0]     r_id, w_id_nxt;
    logic [DW-1:0]      r_data, w_data_nxt;
    logic               w_ack_en, w_beat, w_release;
    logic [IDW-1:0]     w_pick_idx;
    logic               w_pick_any;
    logic [DW-1:0]      w_ch_data [NCH];

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_unpack
            assign w_ch_data[k] = slv_data_i[k*DW +: DW];
        end
    endgenerate

    mcdt_rr_pick #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_pick (
        .req (slv_req_i),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_ack_en  = (r_state == GRANT) & ~rst_i & (~r_val | data_rdy_i);
        a2s_ack_o = '0;
        if (w_ack_en) begin
            a2s_ack_o[r_gnt] = 1'b1;
        end
        w_beat    = w_ack_en & slv_val_i[r_gnt];
        w_cnt_inc = (w_beat && (r_cnt != c_MAX_CNT)) ? r_cnt + 8'd1 : r_cnt;
        // Release on the beat that fills the burst so no extra beat slips in.
        w_release = ~slv_req_i[r_gnt] | (w_cnt_inc == c_MAX_CNT);

        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_gnt == c_LAST_CH) ? '0 : r_gnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_val_nxt  = r_val;
        w_id_nxt   = r_id;
        w_data_nxt = r_data;
        if (w_beat) begin
            w_val_nxt  = 1'b1;
            w_id_nxt   = r_gnt;
            w_data_nxt = w_ch_data[r_gnt];
        end else if (data_rdy_i) begin
            w_val_nxt  = 1'b0;
            w_id_nxt   = c_IDLE_ID_W;
            w_data_nxt = c_IDLE_DATA_W;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_val   <= 1'b0;
            r_id    <= c_IDLE_ID_W;
            r_data  <= c_IDLE_DATA_W;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_val   <= w_val_nxt;
            r_id    <= w_id_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign data_val_o = r_val;
    assign arb_id_o   = r_id;
    assign arb_data_o = r_data;

`ifdef MCDT_ARB_ERR_CHK_EN
    logic r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (|(slv_val_i & ~a2s_ack_o)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire
